aes_round_ctrl: RTL and testbench

//  Iterative AES encrypt round sequencer. Owns the 128-bit state register and

---
 rtl/aes_round_ctrl.sv | 117 +++++++++++
 tb/tb_aes_round_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES encrypt round sequencer (IDLE/ROUND/DONE)
// Optional abort input and logic enabled by defining AES_ABORT_EN.
module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     din,
  output logic [CNT_W-1:0] rk_idx,
  input  logic [127:0]     rk_i,
  output logic [127:0]     rd_din,
  output logic             rd_last,
  input  logic [127:0]     rd_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     dout,
  output logic             busy
`ifdef AES_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NR);

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] rnd_q, rnd_d;
  logic [127:0]     state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             rd_last_q, rd_last_d;

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          // rnd is 0 here, so rk_i is round key 0: initial whitening
          state_d = din ^ rk_i;
          rnd_d   = CNT_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rd_dout;
        if (rnd_q == LAST_RND) begin
          rnd_d = '0;
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
`ifdef AES_ABORT_EN
    if (abort) begin
      fsm_d   = IDLE;
      rnd_d   = '0;
      state_d = state_q;
    end
`endif
    // Outputs are registered from the next state so they track fsm_q exactly
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
    rd_last_d   = (fsm_d == ROUND) && (rnd_d == LAST_RND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rd_last_q   <= rd_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rd_last   = rd_last_q;
  assign rk_idx    = rnd_q;
  assign rd_din    = state_q;
  assign dout      = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl with a reference AES round and key schedule
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] din = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_i;
  logic [127:0] rd_din;
  logic         rd_last;
  logic [127:0] rd_dout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] dout;
  logic         busy;
  logic         abort = 1'b0;

  aes_round_ctrl #(.NR(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .rk_idx(rk_idx), .rk_i(rk_i),
    .rd_din(rd_din), .rd_last(rd_last), .rd_dout(rd_dout),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .busy(busy)
`ifdef AES_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference AES-128 model ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk_tab [16];
  int           key_gen = 0;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] x0, x1, x2, x3;
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    key_gen++;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk_tab[r], r == 10);
    return s;
  endfunction

  // Key schedule and round datapath seen by the DUT
  always @(rk_idx or key_gen) rk_i = rk_tab[rk_idx];
  always @(rd_din or rk_i or rd_last) rd_dout = aes_round(rd_din, rk_i, rd_last);

  // ---------------- scoreboard ----------------
  typedef struct { logic [127:0] ct; int acc; } exp_t;
  exp_t         q [$];
  logic [127:0] exp_ct = '0;
  int           last_acc = 0;
  bit           have_last = 0;
  bit           strm = 0;

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready && !abort) begin
      if (strm && have_last) chk("accept_spacing", 128'(cyc - last_acc), 128'd12);
      chk("accept_rk_idx", 128'(rk_idx), 128'd0);
      q.push_back('{exp_ct, cyc});
      last_acc  = cyc;
      have_last = 1;
    end
  end

  // Round-sequence check: key index steps 1..10 after accept, rd_last only on 10
  always @(negedge clk) begin
    if (!rst && busy && !out_valid) begin
      chk("rk_idx_seq", 128'(rk_idx), 128'(cyc - last_acc));
      chk("rd_last", 128'(rd_last), 128'(rk_idx == 4'd10));
    end
  end

  bit           ov_prev = 0;
  bit           hold_prev = 0;
  logic [127:0] prev_dout = '0;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 0;
      hold_prev = 0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (q.size() == 0) chk("spurious_out_valid", 128'd1, 128'd0);
        else chk("latency", 128'(cyc - q[0].acc), 128'd11);
      end
      if (out_valid && hold_prev) chk("dout_stable", dout, prev_dout);
      if (out_valid) begin
        chk("done_in_ready", 128'(in_ready), 128'd0);
        chk("done_rnd", 128'(rk_idx), 128'd0);
      end
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) chk("handshake_no_expect", 128'd1, 128'd0);
        else begin
          e = q.pop_front();
          chk("dout", dout, e.ct);
        end
      end
      ov_prev   = out_valid;
      hold_prev = out_valid && !out_ready;
      prev_dout = dout;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct);
    bit ok = 0;
    in_valid = 1'b1;
    din      = pt;
    exp_ct   = ct;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready && (q.size() == 0);
    end
    if (!ok) chk("drain_timeout", 128'd0, 128'd1);
    tick();
  endtask

  task automatic wait_rnd(input logic [3:0] r);
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      ok = busy && (rk_idx == r);
    end
    if (!ok) chk("wait_rnd_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_ov();
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      ok = out_valid;
    end
    if (!ok) chk("wait_ov_timeout", 128'd0, 128'd1);
  endtask

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] pts [4];

  initial begin
    build_sbox();
    set_key(KEY_C1);
    repeat (3) tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rd_last", 128'(rd_last), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("rst_dout", dout, 128'd0);
    rst = 1'b0;

    // out_ready in IDLE has no effect
    out_ready = 1'b1;
    repeat (3) tick();
    chk("idle_out_ready_busy", 128'(busy), 128'd0);
    chk("idle_out_ready_ov", 128'(out_valid), 128'd0);

    send(PT_C1, CT_C1);
    wait_drain();

    // Output backpressure for 5 cycles in DONE
    out_ready = 1'b0;
    send(128'h0123456789abcdeffedcba9876543210, aes_enc(128'h0123456789abcdeffedcba9876543210));
    wait_ov();
    repeat (5) tick();
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);

    set_key('0);
    send('0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    wait_drain();
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    wait_drain();
    set_key(KEY_C1);

    // Streaming: in_valid held high across four blocks
    pts[0] = PT_C1;
    pts[1] = 128'hffeeddccbbaa99887766554433221100;
    pts[2] = 128'h00000000000000000000000000000001;
    pts[3] = 128'h80000000000000000000000000000000;
    strm = 1; have_last = 0;
    in_valid = 1'b1; din = pts[0]; exp_ct = CT_C1;
    for (int k = 0; k < 4; k++) begin
      bit ok = 0;
      for (int n = 0; n < 40 && !ok; n++) begin
        @(negedge clk);
        ok = in_ready;
        if (!ok) tick();
      end
      if (!ok) chk("stream_timeout", 128'd0, 128'd1);
      tick();
      if (k < 3) begin din = pts[k+1]; exp_ct = aes_enc(pts[k+1]); end
    end
    in_valid = 1'b0;
    wait_drain();
    strm = 0;

    // in_valid pulsed with junk during ROUND is ignored
    send(PT_C1, CT_C1);
    repeat (3) tick();
    in_valid = 1'b1; din = '1;
    tick();
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-round: block lost, next block correct
    send(pts[1], aes_enc(pts[1]));
    wait_rnd(4'd5);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_rk_idx", 128'(rk_idx), 128'd0);
    q.delete();
    tick();
    rst = 1'b0;
    send(PT_C1, CT_C1);
    wait_drain();

`ifdef AES_ABORT_EN
    send(pts[2], aes_enc(pts[2]));
    wait_rnd(4'd3);
    abort = 1'b1;
    void'(q.pop_back());
    tick();
    abort = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_rk_idx", 128'(rk_idx), 128'd0);
    repeat (15) tick();
    chk("abort_no_ov", 128'(out_valid), 128'd0);

    out_ready = 1'b0;
    send(pts[3], aes_enc(pts[3]));
    wait_ov();
    abort = 1'b1; out_ready = 1'b1;
    void'(q.pop_back());
    tick();
    abort = 1'b0;
    chk("abort_done_ov", 128'(out_valid), 128'd0);
    chk("abort_done_in_ready", 128'(in_ready), 128'd1);
    send(PT_C1, CT_C1);
    wait_drain();
`endif

    repeat (3) tick();
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
